// File: rtl/scan_scheduler.sv
// scan_scheduler: ping-pong scanner sequencer with a per-state watchdog.
// Define SCAN_SCHED_STATS_EN to add the uploadCount statistics port.
module scan_scheduler #(
  parameter int TIMEOUT = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          startReq,
  input  logic          uploadReq,
  input  logic          flushReq,
  input  logic [2:0]    state0,
  input  logic [2:0]    state1,
  output logic [1:0]    cmd0,
  output logic [1:0]    cmd1,
  output logic          xfer0,
  output logic          xfer1,
  output logic          active,
  output logic          busy,
  output logic          error,
  output logic [2:0]    schedState
`ifdef SCAN_SCHED_STATS_EN
  ,output logic [CW-1:0] uploadCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAKE, S_ARM, S_SCAN,
    S_READY, S_XFER, S_FLUSH, S_FAULT
  } sched_t;

  localparam logic [2:0] SC_LP   = 3'd0;
  localparam logic [2:0] SC_SB   = 3'd1;
  localparam logic [2:0] SC_COL  = 3'd2;
  localparam logic [2:0] SC_IDLE = 3'd3;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_SB    = 2'd1;
  localparam logic [1:0] CMD_SCAN  = 2'd2;
  localparam logic [1:0] CMD_FLUSH = 2'd3;

  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  sched_t        st;
  sched_t        st_n;
  logic [CW-1:0] wdog;
  logic          pending;
  logic [1:0]    cmd_n;
  logic          xfer_n;
  logic [2:0]    s_a;
  logic          timed_out;
  logic          xfer_exit;
  logic          counting;

  assign s_a        = active ? state1 : state0;
  assign timed_out  = (wdog == WD_LAST);
  assign xfer_exit  = (st == S_XFER) && (s_a == SC_LP);
  assign schedState = st;

  assign counting = (st == S_WAKE) || (st == S_ARM) ||
                    (st == S_SCAN) || (st == S_XFER) ||
                    (st == S_FLUSH);

  // Exit condition has priority over the watchdog in every wait state.
  always_comb begin
    st_n   = st;
    cmd_n  = CMD_NONE;
    xfer_n = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (startReq) begin
          st_n  = S_WAKE;
          cmd_n = CMD_SB;
        end
      end
      S_WAKE: begin
        if (s_a == SC_SB) begin
          st_n  = S_ARM;
          cmd_n = CMD_SCAN;
        end else if (timed_out) begin
          st_n = S_FAULT;
        end
      end
      S_ARM: begin
        if (s_a == SC_COL)  st_n = S_SCAN;
        else if (timed_out) st_n = S_FAULT;
      end
      S_SCAN: begin
        if (s_a == SC_IDLE) st_n = S_READY;
        else if (timed_out) st_n = S_FAULT;
      end
      S_READY: begin
        if (pending) begin
          st_n   = S_XFER;
          xfer_n = 1'b1;
        end else if (flushReq) begin
          st_n  = S_FLUSH;
          cmd_n = CMD_FLUSH;
        end
      end
      S_XFER: begin
        if (xfer_exit)      st_n = S_IDLE;
        else if (timed_out) st_n = S_FAULT;
      end
      S_FLUSH: begin
        if (s_a == SC_LP)   st_n = S_IDLE;
        else if (timed_out) st_n = S_FAULT;
      end
      S_FAULT: st_n = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= S_IDLE;
      active  <= 1'b0;
      error   <= 1'b0;
      pending <= 1'b0;
      busy    <= 1'b0;
      wdog    <= '0;
      cmd0    <= CMD_NONE;
      cmd1    <= CMD_NONE;
      xfer0   <= 1'b0;
      xfer1   <= 1'b0;
    end else begin
      st    <= st_n;
      busy  <= (st_n != S_IDLE);
      cmd0  <= active ? CMD_NONE : cmd_n;
      cmd1  <= active ? cmd_n : CMD_NONE;
      xfer0 <= xfer_n & ~active;
      xfer1 <= xfer_n & active;
      if (st_n != st)
        wdog <= '0;
      else if (counting && (wdog != '1))
        wdog <= wdog + 1'b1;
      // A request coinciding with the upload exit is dropped.
      if (xfer_exit) begin
        active  <= ~active;
        pending <= 1'b0;
      end else if (uploadReq && (st != S_FAULT)) begin
        pending <= 1'b1;
      end
      if (st_n == S_FAULT)
        error <= 1'b1;
    end
  end

`ifdef SCAN_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      uploadCount <= '0;
    else if (xfer_exit && (uploadCount != '1))
      uploadCount <= uploadCount + 1'b1;
  end
`endif

endmodule

// File: tb/tb_scan_scheduler.sv
// tb_scan_scheduler: random scan cycles against scanner models,
// checked by an event scoreboard plus directed reset/watchdog cases.
module tb_scan_scheduler;

  localparam int TIMEOUT = 32;
  localparam int CW = 8;

  localparam logic [2:0] LP  = 3'd0;
  localparam logic [2:0] SB  = 3'd1;
  localparam logic [2:0] COL = 3'd2;
  localparam logic [2:0] IDL = 3'd3;
  localparam logic [2:0] XF  = 3'd4;
  localparam logic [2:0] FL  = 3'd5;

  localparam int P_START = 0;
  localparam int P_UP    = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic startReq = 1'b0;
  logic uploadReq = 1'b0;
  logic flushReq = 1'b0;
  logic [2:0] state0;
  logic [2:0] state1;
  logic [1:0] cmd0;
  logic [1:0] cmd1;
  logic xfer0;
  logic xfer1;
  logic active;
  logic busy;
  logic error;
  logic [2:0] schedState;
`ifdef SCAN_SCHED_STATS_EN
  logic [CW-1:0] uploadCount;
`endif

  scan_scheduler #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk),
    .reset(reset),
    .startReq(startReq),
    .uploadReq(uploadReq),
    .flushReq(flushReq),
    .state0(state0),
    .state1(state1),
    .cmd0(cmd0),
    .cmd1(cmd1),
    .xfer0(xfer0),
    .xfer1(xfer1),
    .active(active),
    .busy(busy),
    .error(error),
    .schedState(schedState)
`ifdef SCAN_SCHED_STATS_EN
    ,.uploadCount(uploadCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;
    logic       idx;
    logic [1:0] val;
    logic [2:0] st;
    logic [7:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int errors = 0;
  int checks = 0;

  logic m_active = 1'b0;
  bit   m_pending = 1'b0;
  int   m_count = 0;

  logic [2:0] sc_st[2];
  logic [2:0] sc_tgt[2];
  int sc_cnt[2];
  int sb_lat[2];
  bit stuck[2];
  logic [1:0] c_i;
  logic x_i;

  assign state0 = sc_st[0];
  assign state1 = sc_st[1];

  // Scanner behaviour: reacts to one-cycle commands with fixed latencies.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      c_i = (i == 0) ? cmd0 : cmd1;
      x_i = (i == 0) ? xfer0 : xfer1;
      if (reset) begin
        sc_st[i] = LP;
        sc_tgt[i] = LP;
        sc_cnt[i] = 0;
      end else if (!stuck[i]) begin
        if (sc_cnt[i] != 0) begin
          sc_cnt[i]--;
          if (sc_cnt[i] == 0) begin
            sc_st[i] = sc_tgt[i];
            if (sc_st[i] == COL) begin
              sc_tgt[i] = IDL;
              sc_cnt[i] = 10;
            end
          end
        end
        if (c_i == 2'd1 && sc_st[i] == LP) begin
          sc_tgt[i] = SB;
          sc_cnt[i] = sb_lat[i];
        end else if (c_i == 2'd2 && sc_st[i] == SB) begin
          sc_tgt[i] = COL;
          sc_cnt[i] = 1;
        end else if (c_i == 2'd3 && sc_st[i] == IDL) begin
          sc_st[i] = FL;
          sc_tgt[i] = LP;
          sc_cnt[i] = 3;
        end else if (x_i && sc_st[i] == IDL) begin
          sc_st[i] = XF;
          sc_tgt[i] = LP;
          sc_cnt[i] = 3;
        end
      end
    end
  end

  function automatic ev_t mk(input logic [1:0] k, input logic i,
                             input logic [1:0] v, input logic [2:0] s,
                             input logic [7:0] c);
    ev_t e;
    e.kind = k;
    e.idx = i;
    e.val = v;
    e.st = s;
    e.cnt = c;
    return e;
  endfunction

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef SCAN_SCHED_STATS_EN
    return (n > 255) ? 8'hff : 8'(n);
`else
    return (n > 255) ? 8'h0 : 8'h0;
`endif
  endfunction

  function automatic logic [7:0] dut_cnt();
`ifdef SCAN_SCHED_STATS_EN
    return uploadCount;
`else
    return 8'h0;
`endif
  endfunction

  task automatic see(input ev_t e);
    ev_t x;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got=%h required=none", e);
    end else begin
      x = exp_q.pop_front();
      if (x !== e) begin
        errors++;
        $display("FAIL event got=%h required=%h", e, x);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", nm, act, req);
    end
  endtask

  bit pb = 1'b0;
  bit pe = 1'b0;

  // Monitor: every visible pulse, completion or fault is an event.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        pb = 1'b0;
        pe = 1'b0;
      end else begin
        if (cmd0 != 2'd0) see(mk(2'd0, 1'b0, cmd0, schedState, 8'h0));
        if (cmd1 != 2'd0) see(mk(2'd0, 1'b1, cmd1, schedState, 8'h0));
        if (xfer0) see(mk(2'd1, 1'b0, 2'd1, schedState, 8'h0));
        if (xfer1) see(mk(2'd1, 1'b1, 2'd1, schedState, 8'h0));
        if (pb && !busy)
          see(mk(2'd2, active, 2'd0, schedState, dut_cnt()));
        if (!pe && error)
          see(mk(2'd3, active, 2'd0, schedState, 8'h0));
        pb = busy;
        pe = error;
      end
    end
  end

  task automatic pulse(input int which);
    @(negedge clk);
    #1;
    if (which == P_START) startReq = 1'b1;
    else uploadReq = 1'b1;
    @(negedge clk);
    #1;
    startReq = 1'b0;
    uploadReq = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n;
    n = 0;
    while (schedState != s && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wait_state", schedState, s);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_pending = 1'b0;
    m_count = 0;
    exp_q.delete();
  endtask

  task automatic run_cycle(input bit abort_xfer);
    int mode;
    int hold;
    bit drop;
    bit xf;
    logic a;
    a = m_active;
    sb_lat[a] = $urandom_range(1, 4);
    mode = abort_xfer ? 1 : $urandom_range(0, 3);
    drop = !abort_xfer && ($urandom_range(0, 3) == 0);
    if (mode == 1) begin
      pulse(P_UP);
      m_pending = 1'b1;
    end
    flushReq = (mode == 3) ? 1'b0 : 1'($urandom_range(0, 1));
    xf = m_pending || (mode >= 2);
    exp_q.push_back(mk(2'd0, a, 2'd1, 3'd1, 8'h0));
    exp_q.push_back(mk(2'd0, a, 2'd2, 3'd2, 8'h0));
    if (xf) begin
      exp_q.push_back(mk(2'd1, a, 2'd1, 3'd5, 8'h0));
      exp_q.push_back(mk(2'd2, ~a, 2'd0, 3'd0, exp_cnt(m_count + 1)));
    end else begin
      exp_q.push_back(mk(2'd0, a, 2'd3, 3'd6, 8'h0));
      exp_q.push_back(mk(2'd2, a, 2'd0, 3'd0, exp_cnt(m_count)));
    end
    pulse(P_START);
    wait_state(3'd1);
    if ($urandom_range(0, 1) == 1) pulse(P_START);
    if (mode == 2) begin
      wait_state(3'd3);
      pulse(P_UP);
    end
    wait_state(3'd4);
    hold = $urandom_range(0, 4);
    repeat (hold) @(negedge clk);
    #1;
    if (mode == 0) flushReq = 1'b1;
    if (mode == 3) pulse(P_UP);
    if (abort_xfer) begin
      wait_state(3'd5);
      #2 reset = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_state", schedState, 0);
      chk("rst_cmd0", cmd0, 0);
      chk("rst_cmd1", cmd1, 0);
      chk("rst_error", error, 0);
      chk("rst_active", active, 0);
      model_reset();
      flushReq = 1'b0;
      @(negedge clk);
      #1 reset = 1'b0;
      return;
    end
    if (drop && xf) begin
      hold = 0;
      while (!(sc_st[a] == LP && schedState == 3'd5) && hold < 300) begin
        @(negedge clk);
        #1;
        hold++;
      end
      uploadReq = 1'b1;
      @(negedge clk);
      #1 uploadReq = 1'b0;
    end
    wait_state(3'd0);
    flushReq = 1'b0;
    if (xf) begin
      m_active = ~m_active;
      m_pending = 1'b0;
      m_count++;
    end
    chk("cycle_active", active, m_active);
    chk("cycle_busy", busy, 0);
  endtask

  task automatic watchdog();
    int n;
    logic a;
    a = m_active;
    stuck[a] = 1'b1;
    exp_q.push_back(mk(2'd0, a, 2'd1, 3'd1, 8'h0));
    exp_q.push_back(mk(2'd3, a, 2'd0, 3'd7, 8'h0));
    pulse(P_START);
    wait_state(3'd1);
    n = 0;
    while (schedState != 3'd7 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wdog_cycles", n, TIMEOUT);
    chk("wdog_error", error, 1);
    pulse(P_START);
    pulse(P_UP);
    repeat (10) @(negedge clk);
    #1;
    chk("fault_state", schedState, 7);
    chk("fault_error", error, 1);
    chk("fault_busy", busy, 1);
    chk("fault_queue", exp_q.size(), 0);
    reset = 1'b1;
    stuck[a] = 1'b0;
    model_reset();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    stuck[0] = 1'b0;
    stuck[1] = 1'b0;
    sb_lat[0] = 2;
    sb_lat[1] = 2;
    #1 reset = 1'b1;
    #1;
    chk("init_state", schedState, 0);
    chk("init_busy", busy, 0);
    chk("init_error", error, 0);
    chk("init_active", active, 0);
    chk("init_cmd", {cmd0, cmd1}, 0);
    chk("init_xfer", {xfer0, xfer1}, 0);
    chk("init_count", dut_cnt(), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 30; k++) run_cycle(1'b0);
    run_cycle(1'b0);
    run_cycle(1'b1);
    chk("post_rst_count", dut_cnt(), 0);
    for (int k = 0; k < 10; k++) run_cycle(1'b0);
    watchdog();
    for (int k = 0; k < 4; k++) run_cycle(1'b0);
    repeat (3) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
